amba_slave_ctrl: RTL

AXI4-Lite slave front end for the adder register file: terminates the AMBA bus and turns each write/read transaction into the single-cycle register-file write strobe and combinational read address the regfile expects. Sits between the system interconnect and the regfile; write and read paths run as independent FSMs so one channel never blocks the other.

---
 rtl/amba_pkg.sv | 13 +
 rtl/amba_rd_chan.sv | 50 +++++
 rtl/amba_slave_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/amba_pkg.sv
// amba_pkg: AXI4-Lite response codes, channel states and address decode helpers
package amba_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {WR_IDLE, WR_EXEC, WR_RESP} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_RESP} rd_state_t;
  function automatic logic addr_ok(input logic [63:0] a, input int unsigned n);
    return a < 64'(n) * 64'd4 && a[1:0] == 2'b00;
  endfunction
  function automatic logic [31:0] word_idx(input logic [63:0] a);
    return {30'd0, a[3:2]};
  endfunction
endpackage

// File: rtl/amba_rd_chan.sv
// amba_rd_chan: AXI4-Lite read channel FSM with registered RDATA/RRESP
module amba_rd_chan
  import amba_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  output logic [31:0]       addr_rc,
  input  logic [31:0]       data_rc
);
  rd_state_t state;
  logic rd_ok;
  assign arready = !rst && state == RD_IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RD_IDLE;
      rd_ok <= 1'b0;
      rdata <= '0;
      rresp <= RESP_OKAY;
      rvalid <= 1'b0;
      addr_rc <= '0;
    end else case (state)
      RD_IDLE: if (arvalid) begin
        addr_rc <= word_idx(64'(araddr));
        rd_ok <= addr_ok(64'(araddr), NUM_REGS);
        state <= RD_FETCH;
      end
      RD_FETCH: begin
        rdata <= rd_ok ? DATA_W'(data_rc) : '0;
        rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        rvalid <= 1'b1;
        state <= RD_RESP;
      end
      RD_RESP: if (rready) begin
        rvalid <= 1'b0;
        state <= RD_IDLE;
      end
      default: state <= RD_IDLE;
    endcase
endmodule

// File: rtl/amba_slave_ctrl.sv
// amba_slave_ctrl: AXI4-Lite slave turning bus transactions into regfile
// write strobes and read addresses; write and read channels run independently.
module amba_slave_ctrl
  import amba_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 4
) (
  input  logic              ACLK,
  input  logic              ARST,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [31:0]       o_addr_wc,
  output logic [31:0]       o_data_wc,
  output logic              o_en_amba_write,
  output logic [31:0]       o_addr_rc,
  input  logic [31:0]       i_data_rc
);
  wr_state_t wr_state;
  logic aw_got, w_got, wr_ok, aw_hs, w_hs;
  logic [ADDR_W-1:0] aw_q, aw_a;
  logic [DATA_W-1:0] w_q, w_d;
  assign AWREADY = !ARST && wr_state == WR_IDLE && !aw_got;
  assign WREADY = !ARST && wr_state == WR_IDLE && !w_got;
  assign aw_hs = AWVALID && AWREADY;
  assign w_hs = WVALID && WREADY;
  // forward a same-cycle handshake so the strobe follows the final capture by one cycle
  assign aw_a = aw_got ? aw_q : AWADDR;
  assign w_d = w_got ? w_q : WDATA;
  always_ff @(posedge ACLK or posedge ARST)
    if (ARST) begin
      wr_state <= WR_IDLE;
      aw_got <= 1'b0;
      w_got <= 1'b0;
      wr_ok <= 1'b0;
      aw_q <= '0;
      w_q <= '0;
      BRESP <= RESP_OKAY;
      BVALID <= 1'b0;
      o_addr_wc <= '0;
      o_data_wc <= '0;
      o_en_amba_write <= 1'b0;
    end else case (wr_state)
      WR_IDLE: begin
        if (aw_hs) begin
          aw_got <= 1'b1;
          aw_q <= AWADDR;
        end
        if (w_hs) begin
          w_got <= 1'b1;
          w_q <= WDATA;
        end
        if ((aw_got || aw_hs) && (w_got || w_hs)) begin
          aw_got <= 1'b0;
          w_got <= 1'b0;
          wr_ok <= addr_ok(64'(aw_a), NUM_REGS);
          o_en_amba_write <= addr_ok(64'(aw_a), NUM_REGS);
          o_addr_wc <= word_idx(64'(aw_a));
          o_data_wc <= 32'(w_d);
          wr_state <= WR_EXEC;
        end
      end
      WR_EXEC: begin
        o_en_amba_write <= 1'b0;
        BRESP <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        BVALID <= 1'b1;
        wr_state <= WR_RESP;
      end
      WR_RESP: if (BREADY) begin
        BVALID <= 1'b0;
        wr_state <= WR_IDLE;
      end
      default: wr_state <= WR_IDLE;
    endcase
  amba_rd_chan #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rd (
    .clk(ACLK),
    .rst(ARST),
    .araddr(ARADDR),
    .arvalid(ARVALID),
    .arready(ARREADY),
    .rdata(RDATA),
    .rresp(RRESP),
    .rvalid(RVALID),
    .rready(RREADY),
    .addr_rc(o_addr_rc),
    .data_rc(i_data_rc)
  );
endmodule
